// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end.
// Holds the architectural PC, issues one instruction-memory request at a
// time, and buffers returned instructions toward decode over valid/ready.
// Branch/jump redirects retarget the PC and squash any in-flight fetch.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] seq_pc_in,
   output logic [31:0] pc_out,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic [31:0] req_pc_reg;
   logic        kill_reg;
   logic        hold_valid_reg;
   logic [31:0] hold_pc_reg;
   logic [31:0] hold_instr_reg;
   logic        out_valid_reg;
   logic [31:0] out_pc_reg;
   logic [31:0] out_instr_reg;

   logic        buf_free;
   logic [31:0] redirect_aligned;
   logic        unused_redirect_lsbs;

   // Output buffer can take a new instruction when empty or draining this cycle.
   assign buf_free         = ~out_valid_reg | out_ready;
   // Targets are forced to word alignment; the low bits are discarded.
   assign redirect_aligned = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // PC drives the adder directly so seq_pc_in is valid in the same cycle.
   assign pc_out         = pc_reg;
   // Requests only in S_REQ; masked during reset so the bus is quiet at once.
   assign imem_req_valid = (state_reg == S_REQ) & ~rst;
   assign out_valid      = out_valid_reg;
   assign out_pc         = out_pc_reg;
   assign out_instr      = out_instr_reg;

   // Fetch FSM, PC, squash flag, hold register and decode output buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= S_REQ;
         pc_reg         <= RESET_PC;
         req_pc_reg     <= 32'd0;
         kill_reg       <= 1'b0;
         hold_valid_reg <= 1'b0;
         hold_pc_reg    <= 32'd0;
         hold_instr_reg <= 32'd0;
         out_valid_reg  <= 1'b0;
         out_pc_reg     <= 32'd0;
         out_instr_reg  <= NOP_INSTR;
      end else begin
         // A completed transfer empties the buffer unless reloaded below.
         if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end

         if (redirect_valid) begin
            // Redirect wins over everything: retarget and flush buffered work.
            pc_reg         <= redirect_aligned;
            out_valid_reg  <= 1'b0;
            hold_valid_reg <= 1'b0;
            case (state_reg)
               S_REQ: begin
                  // Request accepted this cycle is already stale.
                  if (imem_req_ready) begin
                     kill_reg  <= 1'b1;
                     state_reg <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  // A response landing now is the stale one; nothing left to kill.
                  if (imem_rsp_valid) begin
                     kill_reg  <= 1'b0;
                     state_reg <= S_REQ;
                  end else begin
                     kill_reg <= 1'b1;
                  end
               end
               default: begin
                  state_reg <= S_REQ;
               end
            endcase
         end else begin
            case (state_reg)
               S_REQ: begin
                  if (imem_req_ready) begin
                     req_pc_reg <= pc_reg;
                     pc_reg     <= seq_pc_in;
                     state_reg  <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (imem_rsp_valid) begin
                     if (kill_reg) begin
                        kill_reg  <= 1'b0;
                        state_reg <= S_REQ;
                     end else if (buf_free) begin
                        out_pc_reg    <= req_pc_reg;
                        out_instr_reg <= imem_rsp_data;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_REQ;
                     end else begin
                        hold_pc_reg    <= req_pc_reg;
                        hold_instr_reg <= imem_rsp_data;
                        hold_valid_reg <= 1'b1;
                        state_reg      <= S_HOLD;
                     end
                  end
               end
               default: begin
                  // S_HOLD: drain into the output buffer once decode makes room.
                  if (buf_free) begin
                     out_pc_reg     <= hold_pc_reg;
                     out_instr_reg  <= hold_instr_reg;
                     out_valid_reg  <= 1'b1;
                     hold_valid_reg <= 1'b0;
                     state_reg      <= S_REQ;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: scripted imem/decode stimulus, a bench-side
// adder, and a scoreboard of expected (pc, instr) pairs checked on transfer.
module tb_pc_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic [31:0] seq_pc_in;
   logic [31:0] pc_out;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t sb_q[$];
   int   vectors;
   int   miscompares;

   pc_fetch_unit #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .seq_pc_in      (seq_pc_in),
      .pc_out         (pc_out),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr)
   );

   // The external 32-bit adder with data2 tied to 4.
   assign seq_pc_in = pc_out + 32'd4;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_data(input logic [31:0] addr);
      case (addr)
         32'h0000_0000: mem_data = 32'h00A0_0093;
         32'h0000_0004: mem_data = 32'h0010_8113;
         default:       mem_data = addr ^ 32'h5A5A_0013;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One accepted request followed by a one-cycle-later response.
   task automatic issue_fetch(input logic [31:0] addr, input logic expect_out);
      exp_t e;
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(addr);
      if (expect_out) begin
         e.pc    = addr;
         e.instr = mem_data(addr);
         sb_q.push_back(e);
      end
      tick();
      imem_rsp_valid = 1'b0;
   endtask

   // Scoreboard: every decode transfer must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         exp_t e;
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: got pc=%h instr=%h, required no output", out_pc, out_instr);
         end else begin
            e = sb_q.pop_front();
            if (out_pc !== e.pc || out_instr !== e.instr) begin
               miscompares++;
               $display("FAIL output_xfer: got pc=%h instr=%h, required pc=%h instr=%h",
                        out_pc, out_instr, e.pc, e.instr);
            end else begin
               $display("xfer pc=%h instr=%h ok", out_pc, out_instr);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      vectors++;
      if (pc_out !== RESET_PC || imem_req_valid !== 1'b0 || out_valid !== 1'b0 ||
          out_pc !== 32'd0 || out_instr !== NOP_INSTR) begin
         miscompares++;
         $display("FAIL reset_state: got pc=%h req=%b ov=%b opc=%h oi=%h, required pc=%h req=0 ov=0 opc=0 oi=%h",
                  pc_out, imem_req_valid, out_valid, out_pc, out_instr, RESET_PC, NOP_INSTR);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (imem_req_valid !== 1'b1 || pc_out !== RESET_PC) begin
         miscompares++;
         $display("FAIL first_req: got req=%b pc=%h, required req=1 pc=%h", imem_req_valid, pc_out, RESET_PC);
      end
      $display("reset done");
   endtask

   task automatic test_sequential();
      out_ready = 1'b1;
      issue_fetch(32'h0, 1'b1);
      vectors++;
      if (imem_req_valid !== 1'b1 || pc_out !== 32'h4) begin
         miscompares++;
         $display("FAIL seq_second_req: got req=%b pc=%h, required req=1 pc=00000004", imem_req_valid, pc_out);
      end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      vectors++;
      if (pc_out !== 32'h8 || imem_req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL seq_pc_after_accept: got pc=%h req=%b, required pc=00000008 req=0", pc_out, imem_req_valid);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(32'h4);
      sb_q.push_back('{pc: 32'h4, instr: 32'h0010_8113});
      tick();
      imem_rsp_valid = 1'b0;
      tick();
      $display("sequential done");
   endtask

   task automatic test_decode_stall();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b0;
      issue_fetch(32'h0, 1'b1);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL stall_first_out: got ov=%b opc=%h, required ov=1 opc=00000000", out_valid, out_pc);
      end
      issue_fetch(32'h4, 1'b1);
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (imem_req_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0 ||
             out_instr !== 32'h00A0_0093) begin
            miscompares++;
            $display("FAIL stall_hold: got req=%b ov=%b opc=%h oi=%h, required req=0 ov=1 opc=00000000 oi=00a00093",
                     imem_req_valid, out_valid, out_pc, out_instr);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'h4 || imem_req_valid !== 1'b1 || pc_out !== 32'h8) begin
         miscompares++;
         $display("FAIL stall_release: got ov=%b opc=%h req=%b pc=%h, required ov=1 opc=00000004 req=1 pc=00000008",
                  out_valid, out_pc, imem_req_valid, pc_out);
      end
      $display("decode stall done");
   endtask

   task automatic test_redirect_wait();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_valid = 1'b0;
      vectors++;
      if (pc_out !== 32'h100 || imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL redir_wait_pc: got pc=%h req=%b ov=%b, required pc=00000100 req=0 ov=0",
                  pc_out, imem_req_valid, out_valid);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(32'h8);
      tick();
      imem_rsp_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || pc_out !== 32'h100) begin
         miscompares++;
         $display("FAIL redir_wait_drop: got ov=%b req=%b pc=%h, required ov=0 req=1 pc=00000100",
                  out_valid, imem_req_valid, pc_out);
      end
      issue_fetch(32'h100, 1'b1);
      $display("redirect in wait done");
   endtask

   task automatic test_redirect_accept();
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      vectors++;
      if (pc_out !== 32'h200 || imem_req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL redir_accept_pc: got pc=%h req=%b, required pc=00000200 req=0", pc_out, imem_req_valid);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(32'h104);
      tick();
      imem_rsp_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || pc_out !== 32'h200) begin
         miscompares++;
         $display("FAIL redir_accept_drop: got ov=%b req=%b pc=%h, required ov=0 req=1 pc=00000200",
                  out_valid, imem_req_valid, pc_out);
      end
      issue_fetch(32'h200, 1'b1);
      $display("redirect on accept done");
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      vectors++;
      if (pc_out !== 32'hFFFF_FFFC || imem_req_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_target: got pc=%h req=%b, required pc=fffffffc req=1", pc_out, imem_req_valid);
      end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      vectors++;
      if (pc_out !== 32'h0) begin
         miscompares++;
         $display("FAIL wrap_pc: got pc=%h, required pc=00000000", pc_out);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(32'hFFFF_FFFC);
      tick();
      imem_rsp_valid = 1'b0;
      // Hold this output in the buffer so the async reset test can see it vanish.
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== (32'hFFFF_FFFC ^ 32'h5A5A_0013) ||
          imem_req_valid !== 1'b1 || pc_out !== 32'h0) begin
         miscompares++;
         $display("FAIL wrap_out: got ov=%b opc=%h oi=%h req=%b pc=%h, required ov=1 opc=fffffffc oi=%h req=1 pc=00000000",
                  out_valid, out_pc, out_instr, imem_req_valid, pc_out, 32'hFFFF_FFFC ^ 32'h5A5A_0013);
      end
      $display("wrap done");
   endtask

   task automatic test_async_reset();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_out !== RESET_PC || out_instr !== NOP_INSTR) begin
         miscompares++;
         $display("FAIL async_reset: got ov=%b req=%b pc=%h oi=%h, required ov=0 req=0 pc=%h oi=%h",
                  out_valid, imem_req_valid, pc_out, out_instr, RESET_PC, NOP_INSTR);
      end
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      #1;
      vectors++;
      if (imem_req_valid !== 1'b1 || pc_out !== RESET_PC) begin
         miscompares++;
         $display("FAIL post_reset_req: got req=%b pc=%h, required req=1 pc=%h", imem_req_valid, pc_out, RESET_PC);
      end
      tick();
      imem_rsp_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL late_rsp_ignored: got ov=%b, required ov=0", out_valid);
      end
      issue_fetch(RESET_PC, 1'b1);
      tick();
      tick();
      $display("async reset done");
   endtask

   task automatic test_drain();
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
      end
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      out_ready      = 1'b1;
      test_reset();
      test_sequential();
      test_decode_stall();
      test_redirect_wait();
      test_redirect_accept();
      test_wrap();
      test_async_reset();
      test_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch front end of the RISC-V core, directly upstream and downstream of the 32-bit `add` block.
- Holds the architectural PC and drives it onto pc_out, which is wired to add.data1; add.data2 is tied to 32'd4.
- Consumes add.add_result as the sequential next PC.
- Issues one instruction-memory request at a time and buffers the returned instruction toward decode over a valid/ready handshake.
- Handles branch/jump redirects, including squashing an in-flight fetch.

Parameters:
RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
NOP_INSTR  32'h0000_0013  value of out_instr while reset (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-high
seq_pc_in  input  32  add_result from adder (pc_out + 4), combinational
pc_out  output  32  current PC; to adder data1 and imem address
imem_req_valid  output  1  fetch request at address pc_out
imem_req_ready  input  1  memory accepts request this cycle
imem_rsp_valid  input  1  instruction returned (no backpressure, ≥1 cycle after accept)
imem_rsp_data  input  32  returned instruction
redirect_valid  input  1  branch/jump taken; one-cycle pulse
redirect_pc  input  32  target PC
out_valid  output  1  fetched instruction available to decode
out_ready  input  1  decode accepts
out_pc  output  32  PC of out_instr
out_instr  output  32  fetched instruction

Behaviour:
- Reset: one clock; rst is asynchronous and active-high.
  - While rst=1: pc_reg=RESET_PC, state=S_REQ, imem_req_valid=0, out_valid=0, out_pc=0, out_instr=NOP_INSTR, kill=0, hold_valid=0.
  - First request is asserted the first cycle after rst deasserts.
  - rst mid-fetch abandons everything; the late response is ignored because the state machine is back in S_REQ.
- pc_out = pc_reg always, so the adder output is valid in the same cycle.
- States:
  - S_REQ: imem_req_valid=1. On imem_req_ready: req_pc<=pc_reg, pc_reg<=seq_pc_in, go to S_WAIT.
  - S_WAIT: imem_req_valid=0. Waits for imem_rsp_valid.
    - If kill=1: drop the response, kill<=0, go to S_REQ.
    - Else, if the output buffer is free (out_valid=0 or out_ready=1): out_pc<=req_pc, out_instr<=imem_rsp_data, out_valid<=1, go to S_REQ.
    - Else: capture into the hold register, go to S_HOLD.
  - S_HOLD: imem_req_valid=0. When the buffer frees, move hold→out, go to S_REQ.
- Output handshake:
  - Transfer occurs on out_valid & out_ready.
  - out_valid drops the next cycle unless it is reloaded in the same cycle.
  - out_pc and out_instr are stable while out_valid=1 and out_ready=0.
- Redirect (highest priority, any state):
  - pc_reg<={redirect_pc[31:2],2'b00}; out_valid<=0; hold_valid<=0.
  - S_WAIT: kill<=1, stay in S_WAIT. If imem_rsp_valid arrives in the same cycle, that response is dropped and the FSM goes to S_REQ with kill=0.
  - S_REQ with imem_req_ready in the same cycle: the request is outstanding but stale, so kill<=1 and go to S_WAIT. pc_reg takes redirect_pc, not seq_pc_in.
  - S_HOLD: go to S_REQ.
- Throughput: at most one outstanding request; the best case is one instruction per 2 cycles (request, response).
- Wrap-around: PC arithmetic is modulo 2^32 in the adder; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: rst pulse; imem always ready; responses 1 cycle later returning 32'h00A00093 and 32'h00108113; out_ready=1.
  - Required: requests at 0x0 then 0x4; outputs (0x0, 00A00093) then (0x4, 00108113); pc_out=0x8 after the second accept.
- Decode stall:
  - Stimulus: out_ready=0 while a second response arrives.
  - Required: FSM in S_HOLD; out_pc=0x0 held stable; no new imem_req_valid. After out_ready=1, the 0x4 instruction appears on the next cycle.
- Redirect during S_WAIT:
  - Stimulus: redirect_pc=0x100 asserted while fetch of 0x8 is outstanding.
  - Required: the 0x8 response is dropped; out_valid stays 0; next request at 0x100; then output (0x100, data).
- Redirect in the same cycle as request accept:
  - Stimulus: redirect to 0x203 coincident with imem_req_ready.
  - Required: pc_reg=0x200; the first response is dropped; the next request is at 0x200.
- Wrap-around:
  - Stimulus: redirect to 0xFFFFFFFC, then fetch.
  - Required: output (0xFFFFFFFC, data); next request at 0x00000000.
- Asynchronous reset mid-fetch:
  - Stimulus: rst asserted between clock edges while in S_WAIT.
  - Required: out_valid and imem_req_valid go to 0 immediately; after release, the request is at RESET_PC; the late response produces no output.
